// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM at the far end of the EX/MEM
// interface. Serves one load/store at a time with WAIT_STATES extra cycles of
// latency, holds the pipeline with o_stall while busy, and reports misaligned
// and out-of-range accesses with the 4-bit exception code (4'b1111 = none).
// Optional build macro DMEM_SUBWORD_EN adds byte/halfword accesses through
// the i_size/i_unsigned ports; without it every access is a full word.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
`ifdef DMEM_SUBWORD_EN
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
`endif
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_stall,
  output logic [3:0]  o_exception_code
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [3:0]  EXC_NONE = 4'b1111;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] rdata_q, rdata_d;

  // Request captured at acceptance so a late-dropped i_req still completes.
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
`ifdef DMEM_SUBWORD_EN
  logic [1:0]  size_q;
  logic        uns_q;
`endif

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] req_off;
  logic        misalign, range_fault;

  logic        a_we;
  logic [31:0] a_addr, a_wdata, a_off;
  logic [AW-1:0] a_idx;
  logic [3:0]  a_be;
  logic [31:0] a_wlane, a_word, a_load;
`ifdef DMEM_SUBWORD_EN
  logic [1:0]  a_size;
  logic        a_uns;
  logic [31:0] a_shift;
`endif
  logic        acc_go;

  // Fault classification of the incoming request; misalignment wins.
  always_comb begin
    req_off = i_addr - BASE_ADDR;
`ifdef DMEM_SUBWORD_EN
    case (i_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = i_addr[0];
      default: misalign = |i_addr[1:0];
    endcase
`else
    misalign = |i_addr[1:0];
`endif
    range_fault = (req_off >= LIMIT);
  end

  // Access operands: live inputs for a zero-wait access from IDLE, else the captured request.
  always_comb begin
    if (state_q == IDLE) begin
      a_we    = i_we;
      a_addr  = i_addr;
      a_wdata = i_wdata;
`ifdef DMEM_SUBWORD_EN
      a_size  = i_size;
      a_uns   = i_unsigned;
`endif
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
`ifdef DMEM_SUBWORD_EN
      a_size  = size_q;
      a_uns   = uns_q;
`endif
    end
    a_off = a_addr - BASE_ADDR;
    a_idx = AW'(a_off >> 2);
  end

  // Byte-lane enables, store lane data and load extraction for the current access.
  always_comb begin
    a_word  = mem_q[a_idx];
    a_be    = 4'b1111;
    a_wlane = a_wdata;
    a_load  = a_word;
`ifdef DMEM_SUBWORD_EN
    a_shift = a_word >> {a_addr[1:0], 3'b000};
    case (a_size)
      2'b00: begin
        a_be    = 4'b0001 << a_addr[1:0];
        a_wlane = {4{a_wdata[7:0]}};
        a_load  = a_uns ? {24'd0, a_shift[7:0]} : {{24{a_shift[7]}}, a_shift[7:0]};
      end
      2'b01: begin
        a_be    = 4'b0011 << a_addr[1:0];
        a_wlane = {2{a_wdata[15:0]}};
        a_load  = a_uns ? {16'd0, a_shift[15:0]} : {{16{a_shift[15]}}, a_shift[15:0]};
      end
      default: ;
    endcase
`endif
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    rdata_d = rdata_q;
    acc_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          if (misalign) begin
            code_d  = i_we ? 4'd6 : 4'd4;
            rdata_d = '0;
            state_d = DONE;
          end else if (range_fault) begin
            code_d  = i_we ? 4'd7 : 4'd5;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            code_d = EXC_NONE;
            if (WAIT_STATES == 0) begin
              state_d = DONE;
              acc_go  = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = WS_INIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = EXC_NONE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_go && !a_we) rdata_d = a_load;
  end

  // Control and response registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      code_q  <= EXC_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  // Capture the request on acceptance.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_req) begin
      we_q    <= i_we;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
`ifdef DMEM_SUBWORD_EN
      size_q  <= i_size;
      uns_q   <= i_unsigned;
`endif
    end
  end

  // RAM write on the edge entering DONE; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && acc_go && a_we) begin
      for (int b = 0; b < 4; b++) begin
        if (a_be[b]) mem_q[a_idx][8*b +: 8] <= a_wlane[8*b +: 8];
      end
    end
  end

  assign o_rdata          = rdata_q;
  assign o_ready          = (state_q == DONE);
  assign o_exception_code = code_q;
  assign o_stall          = i_rst_n && (((state_q == IDLE) && i_req) || (state_q == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=2 and 0) driven by
// directed and randomized requests; a byte-level reference model predicts each
// response, which a per-instance monitor checks when o_ready pulses.
module tb_dmem_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  c;
    bit          chk;
    longint      t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2], we[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic        ready[2], stall[2];
  logic [3:0]  code[2];
`ifdef DMEM_SUBWORD_EN
  logic [1:0]  size[2];
  logic        uns[2];
`endif

  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  exp_t   q0[$];
  exp_t   q1[$];

  logic [7:0] rb[2][4096];
  bit         kb[2][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(WS0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_we(we[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]),
`ifdef DMEM_SUBWORD_EN
    .i_size(size[0]), .i_unsigned(uns[0]),
`endif
    .o_rdata(rdata[0]), .o_ready(ready[0]), .o_stall(stall[0]),
    .o_exception_code(code[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(WS1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_we(we[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]),
`ifdef DMEM_SUBWORD_EN
    .i_size(size[1]), .i_unsigned(uns[1]),
`endif
    .o_rdata(rdata[1]), .o_ready(ready[1]), .o_stall(stall[1]),
    .o_exception_code(code[1])
  );

  function automatic int ws(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, RAM spans bytes 0..4095.
  function automatic void model(input int k, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input int sz, input bit u,
                                output logic [3:0] c, output logic [31:0] rd,
                                output bit known);
    int nb;
    logic [31:0] val;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    rd = 32'h0;
    known = 1'b1;
    if ((a % nb) != 0)       c = w ? 4'd6 : 4'd4;
    else if (a >= 32'd4096)  c = w ? 4'd7 : 4'd5;
    else                     c = 4'hF;
    if (c == 4'hF) begin
      if (w) begin
        for (int i = 0; i < nb; i++) begin
          rb[k][int'(a) + i] = d[8*i +: 8];
          kb[k][int'(a) + i] = 1'b1;
        end
        known = 1'b0;
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) begin
          val[8*i +: 8] = rb[k][int'(a) + i];
          if (!kb[k][int'(a) + i]) known = 1'b0;
        end
        if (!u && nb < 4 && val[8*nb-1]) begin
          for (int b = 8*nb; b < 32; b++) val[b] = 1'b1;
        end
        rd = val;
      end
    end else if (w) begin
      known = 1'b0;
    end
  endfunction

  // Issue one request at posedge+1; returns one cycle after its DONE cycle.
  task automatic do_req(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int sz, input bit u);
    exp_t e;
    int   lat;
    model(k, w, a, d, sz, u, e.c, e.rd, e.chk);
    lat = (e.c == 4'hF) ? ws(k) : 0;
    e.t = cyc + 1 + lat;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
`ifdef DMEM_SUBWORD_EN
    size[k] = sz[1:0]; uns[k] = u;
`endif
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check("stall_busy", 32'(stall[k]), 32'd1);
    end
    @(negedge clk);
    check("stall_done", 32'(stall[k]), 32'd0);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic rand_op(input int k);
    int sel, sz, nb;
    bit w, u;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    w   = 1'($urandom_range(0, 1));
    sz  = 2;
    u   = 1'b0;
`ifdef DMEM_SUBWORD_EN
    sz = $urandom_range(0, 3);
    u  = 1'($urandom_range(0, 1));
`endif
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    if (sel < 7)       a = 32'($urandom_range(0, 255)) & ~(32'(nb) - 32'd1);
    else if (sel == 7) a = 32'($urandom_range(0, 255)) | 32'd1;
    else               a = $urandom() | 32'h0001_0000;
    do_req(k, w, a, $urandom(), sz, u);
  endtask

  task automatic score(input int k);
    exp_t e;
    bit   empty;
    if (k == 0) begin
      empty = (q0.size() == 0);
      if (!empty) e = q0.pop_front();
    end else begin
      empty = (q1.size() == 0);
      if (!empty) e = q1.pop_front();
    end
    if (empty) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_ready: dut%0d got o_ready=1, expected no response (t=%0t)", k, $time);
    end else begin
      check("ready_cycle", 32'(cyc), 32'(e.t));
      check("exc_code", 32'(code[k]), 32'(e.c));
      if (e.chk) check("rdata", rdata[k], e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ready[0]) score(0); else check("code_idle0", 32'(code[0]), 32'hF);
      if (ready[1]) score(1); else check("code_idle1", 32'(code[1]), 32'hF);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b1; we[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
`ifdef DMEM_SUBWORD_EN
      size[k] = 2'b10; uns[k] = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_ready", 32'(ready[k]), 32'd0);
      check("rst_stall", 32'(stall[k]), 32'd0);
      check("rst_code", 32'(code[k]), 32'hF);
      req[k] = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic store/load, WAIT_STATES=2
    do_req(0, 1'b1, 32'h20, 32'hCAFE_F00D, 2, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0, 2, 1'b0);

    // Reset during the first WAIT cycle aborts the store
    do_req(0, 1'b1, 32'h10, 32'h0, 2, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("midrst_rdata", rdata[0], 32'h0);
    check("midrst_ready", 32'(ready[0]), 32'd0);
    check("midrst_stall", 32'(stall[0]), 32'd0);
    check("midrst_code", 32'(code[0]), 32'hF);
    req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h10, 32'h0, 2, 1'b0);

    // Misaligned and out-of-range
    do_req(0, 1'b1, 32'h22, 32'h1234_5678, 2, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0, 2, 1'b0);
    do_req(0, 1'b0, 32'h21, 32'h0, 2, 1'b0);
    do_req(0, 1'b0, 32'h1000, 32'h0, 2, 1'b0);
    do_req(0, 1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 2, 1'b0);
    do_req(0, 1'b1, 32'hFFC, 32'hA5A5_0FF0, 2, 1'b0);
    do_req(0, 1'b0, 32'hFFC, 32'h0, 2, 1'b0);

    // Zero wait states, back-to-back loads
    do_req(1, 1'b1, 32'h0, 32'h0BAD_F00D, 2, 1'b0);
    do_req(1, 1'b0, 32'h0, 32'h0, 2, 1'b0);
    do_req(1, 1'b0, 32'h0, 32'h0, 2, 1'b0);
    do_req(1, 1'b0, 32'h1001, 32'h0, 2, 1'b0);

`ifdef DMEM_SUBWORD_EN
    do_req(0, 1'b1, 32'h40, 32'h1122_3344, 2, 1'b0);
    do_req(0, 1'b1, 32'h41, 32'h0000_0080, 0, 1'b0);
    do_req(0, 1'b0, 32'h41, 32'h0, 0, 1'b0);
    do_req(0, 1'b0, 32'h40, 32'h0, 1, 1'b1);
    do_req(0, 1'b0, 32'h43, 32'h0, 1, 1'b0);
`endif

    // Randomized traffic over a preloaded region
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) do_req(k, 1'b1, 32'(i * 4), $urandom(), 2, 1'b0);
      for (int i = 0; i < 120; i++) rand_op(k);
    end

    repeat (3) @(negedge clk);
    check("sb_drain0", 32'(q0.size()), 32'd0);
    check("sb_drain1", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
